// File: rtl/dfp_arbiter_pkg.sv
// Shared memory-side types for the DFP line arbiter: FSM states, client ids and
// line geometry constants.
package dfp_arbiter_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int LINE_WIDTH  = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } arb_client_t;

endpackage

// File: rtl/dfp_arbiter_rr_pick2.sv
// Two-way round-robin picker: on contention, grants whichever client did not
// win last time. grant is an arb_client_t encoding (1 = D-cache).
module rr_pick2
    import dfp_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_valid = req_i | req_d;
        grant       = req_d;
        if (req_i && req_d) begin
            grant = (arb_client_t'(last_grant) == CLIENT_I);
        end
    end

endmodule

// File: rtl/dfp_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto the single DFP line
// interface, holding the granted request until the deserializer responds.
module dfp_arbiter
    import dfp_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = dfp_arbiter_pkg::ADDR_WIDTH,
    parameter int LINE_WIDTH  = dfp_arbiter_pkg::LINE_WIDTH,
    parameter int OFFSET_BITS = dfp_arbiter_pkg::OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_read,
    output logic                  m_write,
    output logic [LINE_WIDTH-1:0] m_wdata,
    input  logic [LINE_WIDTH-1:0] m_rdata,
    input  logic                  m_resp
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    arb_state_t            state_q, state_d;
    arb_client_t           owner_q, owner_d;
    arb_client_t           last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  m_read_q, m_read_d;
    logic                  m_write_q, m_write_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  i_resp_q, i_resp_d;
    logic                  d_resp_q, d_resp_d;

    logic pick_valid;
    logic pick_grant;
    logic grant_write;

    rr_pick2 u_pick (
        .req_i       (i_read),
        .req_d       (d_read | d_write),
        .last_grant  (last_grant_q),
        .grant_valid (pick_valid),
        .grant       (pick_grant)
    );

    // A D request with both d_read and d_write set is served as a write.
    assign grant_write = pick_grant & d_write;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        m_read_d     = m_read_q;
        m_write_d    = m_write_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d      = arb_client_t'(pick_grant);
                    last_grant_d = arb_client_t'(pick_grant);
                    addr_d       = (pick_grant ? d_addr : i_addr) & ADDR_MASK;
                    wdata_d      = grant_write ? d_wdata : '0;
                    m_read_d     = ~grant_write;
                    m_write_d    = grant_write;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (m_resp) begin
                    if (!m_write_q) begin
                        if (owner_q == CLIENT_I) i_rdata_d = m_rdata;
                        else                     d_rdata_d = m_rdata;
                    end
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    i_resp_d  = (owner_q == CLIENT_I);
                    d_resp_d  = (owner_q == CLIENT_D);
                    state_d   = RESP;
                end
            end
            // The client still holds its request during RESP, so nothing is sampled here.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= CLIENT_I;
            last_grant_q <= CLIENT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            m_read_q     <= m_read_d;
            m_write_q    <= m_write_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign m_read  = m_read_q;
    assign m_write = m_write_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_resp  = i_resp_q;
    assign d_resp  = d_resp_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_d_op_legal: assert (!(state_q == IDLE && d_read && d_write))
                else $warning("dfp_arbiter: d_read and d_write both set, served as write");
            a_resp_in_busy: assert (!(m_resp && state_q != BUSY))
                else $warning("dfp_arbiter: m_resp outside BUSY ignored");
        end
    end

endmodule
